// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: single-outstanding load/store bridge from core requests to a word-wide valid/ready bus.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of forcing natural alignment.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic                 wr_q;
  logic [2:0]           funct3_q;
  logic [31:0]          addr_q, wdata_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 err_q;
  logic [31:0]          rdata_q;

  logic                 req_illegal, expired;
  logic [31:0]          addr_eff, rd_shift, rd_ext, wdata_lane;
  logic [3:0]           be;

  // Illegal check runs on the live request so a bad access never reaches the bus.
  always_comb begin
    req_illegal = req_wr ? (req_funct3 >= 3'd3)
                         : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'd1 && req_addr[0])          req_illegal = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00) req_illegal = 1'b1;
    addr_eff = addr_q;
`else
    addr_eff = addr_q;
    if (funct3_q[1:0] == 2'd1)      addr_eff[0]   = 1'b0;
    else if (funct3_q[1:0] == 2'd2) addr_eff[1:0] = 2'b00;
`endif
  end

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata_q;
    case (funct3_q[1:0])
      2'd0: begin
        be         = 4'b0001 << addr_eff[1:0];
        wdata_lane = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be         = addr_eff[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase

    rd_shift = bus_rdata >> {addr_eff[1:0], 3'b000};
    rd_ext   = rd_shift;
    case (funct3_q)
      3'd0:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    rd_ext = {24'b0, rd_shift[7:0]};
      3'd5:    rd_ext = {16'b0, rd_shift[15:0]};
      default: ;
    endcase
  end

  assign expired = (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  // Expiry in ADDR wins over bus_ready; in RESP a same-cycle bus_rvalid wins over expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = req_illegal ? DONE : ADDR;
      ADDR: begin
        if (expired)        state_nxt = DONE;
        else if (bus_ready) state_nxt = RESP;
      end
      RESP: if (bus_rvalid || expired) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_q     <= req_wr;
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          cnt_q    <= '0;
          err_q    <= req_illegal;
          rdata_q  <= '0;
        end
        ADDR: begin
          cnt_q <= cnt_q + 1'b1;
          if (expired) err_q <= 1'b1;
        end
        RESP: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_rvalid)   rdata_q <= wr_q ? '0 : rd_ext;
          else if (expired) err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign bus_valid = (state == ADDR);
  assign bus_addr  = bus_valid ? {addr_eff[31:2], 2'b00} : '0;
  assign bus_wr    = bus_valid & wr_q;
  assign bus_be    = bus_valid ? be : 4'b0000;
  assign bus_wdata = bus_valid ? wdata_lane : '0;
  assign rsp_valid = (state == DONE);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the core's data-side request and a word-wide data bus with valid/ready request and rvalid response handshakes.
- Accepts one load or store at a time and aligns store data into byte lanes with byte enables.
- Extracts and sign- or zero-extends load data per funct3.
- Flags illegal or timed-out accesses. Sits directly downstream of the core's d_addr/d_wr_en/d_be/d_data path.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed from entering ADDR until bus_rvalid before error (1..2^TIMEOUT_W-1)
TIMEOUT_W, 8, width of the timeout counter

Ports:
clk  input  1  clock, all state on rising edge
rstb  input  1  asynchronous active-low reset
req_valid  input  1  core access request; accepted only when busy=0
req_wr  input  1  1=store, 0=load
req_funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address
req_wdata  input  32  store data, value in low bits
busy  output  1  high from the cycle after accept through the rsp_valid cycle
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load result; 0 for stores and errors
rsp_err  output  1  qualifies rsp_valid: illegal, misaligned (macro) or timeout
bus_valid  output  1  bus request valid
bus_ready  input  1  bus accepts request
bus_addr  output  32  word address, bits [1:0]=0
bus_wr  output  1  write request
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_rvalid  input  1  response/write-ack valid
bus_rdata  input  32  read data word

Behaviour:
- Reset: state IDLE; all outputs 0; counter 0; latched request fields 0. Reset mid-operation aborts the transfer with no rsp_valid. A bus_rvalid still outstanding after reset is ignored.
- IDLE: req_valid=1 latches all req_* fields. Next state is ADDR, or DONE with error if the access is illegal.
- Illegal access:
  - loads: funct3 = 3, 6 or 7
  - stores: funct3 >= 3
  - result: no bus transaction; rsp_err=1.
- ADDR: bus_valid=1 with bus_addr/bus_wr/bus_be/bus_wdata held stable until bus_valid & bus_ready are sampled together, then go to RESP.
- RESP: wait for bus_rvalid, then go to DONE. bus_rvalid is ignored in every other state. Stores also wait for bus_rvalid as the write acknowledge.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. req_valid in the DONE cycle is ignored; the earliest next accept is the following cycle.
- Minimum latency: accept at cycle 0, bus_valid at 1 (ready=1), rvalid at 2, rsp_valid at 3.
- Timeout:
  - Counter clears on entry to ADDR and increments each cycle in ADDR or RESP.
  - Reaching TIMEOUT_CYCLES goes to DONE with rsp_err=1, rsp_rdata=0, bus_valid dropped.
  - If bus_rvalid arrives in the same cycle as expiry, rvalid wins and there is no error.
- Store lanes:
  - SB: be = 1 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated x2.
  - SW: be = 4'b1111.
- Loads: bus_be per width as for stores. Shift bus_rdata right by 8*addr[1:0], then LB/LH sign-extend, LBU/LHU zero-extend, LW pass through. The result is registered with bus_rvalid and presented on rsp_rdata in DONE.
- rsp_rdata and rsp_err are valid only while rsp_valid=1; otherwise they are 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, is treated as illegal.
  - No bus transaction; rsp_valid+rsp_err occur in the cycle after accept.
- Undefined:
  - Misaligned addresses are forced to natural alignment: addr[0] cleared for H, addr[1:0] cleared for W.
  - The access proceeds normally; rsp_err is raised only for illegal funct3 or timeout.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, bus_ready/rvalid immediate -> bus_addr 0x104, be 0xF, wdata 0xDEADBEEF; rsp_valid at cycle 3, rsp_err 0.
- LB addr 0x203, bus_rdata 0x80FF1234 -> be 0x8, rsp_rdata 0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x12, wdata 0x0000ABCD -> be 0xC, bus_wdata 0xABCDABCD. LH addr 0x12 with rdata 0x7FFF0000 -> 0x00007FFF.
- bus_ready held low 3 cycles -> bus_valid and all bus_* fields stable across those cycles. req_valid pulses while busy are ignored; exactly one rsp_valid.
- No bus_rvalid with TIMEOUT_CYCLES=4 -> rsp_valid with rsp_err=1 and rsp_rdata 0 four cycles after entering ADDR. Then rstb pulsed low mid-ADDR -> all outputs 0, IDLE.
- LW addr 0x102:
  - with LSU_MISALIGN_TRAP_EN -> no bus_valid; rsp_err=1 the cycle after accept.
  - without -> bus_addr 0x100, be 0xF, rsp_err 0.
  - load funct3=3 -> rsp_err=1 in both builds.
